// File: rtl/decode_stage.sv
// decode_stage: instruction decode stage of the 5-stage RV32I pipeline.
// It holds the integer register file, which the writeback stage writes and
// which returns the new value when a register is read in the same cycle it is
// written. It also generates immediates, decodes the main and ALU controls,
// and ends in the ID/EX pipeline register.
// Optional build macro DECODE_ILLEGAL_EN adds the registered illegalE flag.
module decode_stage #(
    parameter int XLEN = 32,
    parameter int NREG = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [31:0]     instrD,
    input  logic [XLEN-1:0] pcD,
    input  logic [XLEN-1:0] pc4D,
    input  logic            flushE,
    input  logic            regwriteW,
    input  logic [4:0]      rdW,
    input  logic [XLEN-1:0] resultW,
    output logic [4:0]      rs1D,
    output logic [4:0]      rs2D,
    output logic [XLEN-1:0] rd1E,
    output logic [XLEN-1:0] rd2E,
    output logic [XLEN-1:0] immE,
    output logic [XLEN-1:0] pcE,
    output logic [XLEN-1:0] pc4E,
    output logic [4:0]      rs1E,
    output logic [4:0]      rs2E,
    output logic [4:0]      rdE,
    output logic            regwriteE,
    output logic            memwriteE,
    output logic [1:0]      resultsrcE,
    output logic            alusrcaE,
    output logic            alusrcbE,
    output logic [3:0]      aluctrlE,
    output logic            branchE,
    output logic            jumpE,
    output logic [2:0]      funct3E
`ifdef DECODE_ILLEGAL_EN
    ,
    output logic            illegalE
`endif
);

    // Major opcodes
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    // ALU operation codes
    localparam logic [3:0] ALU_ADD   = 4'd0;
    localparam logic [3:0] ALU_SUB   = 4'd1;
    localparam logic [3:0] ALU_SLL   = 4'd2;
    localparam logic [3:0] ALU_SLT   = 4'd3;
    localparam logic [3:0] ALU_SLTU  = 4'd4;
    localparam logic [3:0] ALU_XOR   = 4'd5;
    localparam logic [3:0] ALU_SRL   = 4'd6;
    localparam logic [3:0] ALU_SRA   = 4'd7;
    localparam logic [3:0] ALU_OR    = 4'd8;
    localparam logic [3:0] ALU_AND   = 4'd9;
    localparam logic [3:0] ALU_PASSB = 4'd10;

    logic [XLEN-1:0] regs_r [NREG];

    logic [6:0]      opcode_s;
    logic [2:0]      funct3_s;
    logic [6:0]      funct7_s;
    logic [4:0]      rdIdx_s;
    logic [XLEN-1:0] rd1_s;
    logic [XLEN-1:0] rd2_s;
    logic [XLEN-1:0] imm_s;
    logic            legal_s;
    logic            regwrite_s;
    logic            memwrite_s;
    logic [1:0]      resultsrc_s;
    logic            alusrca_s;
    logic            alusrcb_s;
    logic [3:0]      aluctrl_s;
    logic            branch_s;
    logic            jump_s;

    assign opcode_s = instrD[6:0];
    assign funct3_s = instrD[14:12];
    assign funct7_s = instrD[31:25];
    assign rdIdx_s  = instrD[11:7];
    assign rs1D     = instrD[19:15];
    assign rs2D     = instrD[24:20];

    // Register file storage: cleared on reset, x0 is never written
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs_r[i] <= {XLEN{1'b0}};
            end
        end else if (regwriteW && (rdW != 5'd0)) begin
            regs_r[rdW] <= resultW;
        end
    end

    // Register file read ports with bypass of the write happening this cycle
    always_comb begin
        rd1_s = {XLEN{1'b0}};
        rd2_s = {XLEN{1'b0}};
        if (rs1D == 5'd0) begin
            rd1_s = {XLEN{1'b0}};
        end else if (regwriteW && (rdW == rs1D)) begin
            rd1_s = resultW;
        end else begin
            rd1_s = regs_r[rs1D];
        end
        if (rs2D == 5'd0) begin
            rd2_s = {XLEN{1'b0}};
        end else if (regwriteW && (rdW == rs2D)) begin
            rd2_s = resultW;
        end else begin
            rd2_s = regs_r[rs2D];
        end
    end

    // Main and ALU control decode, immediate generation and legality check
    always_comb begin
        imm_s       = {XLEN{1'b0}};
        legal_s     = 1'b1;
        regwrite_s  = 1'b0;
        memwrite_s  = 1'b0;
        resultsrc_s = 2'd0;
        alusrca_s   = 1'b0;
        alusrcb_s   = 1'b0;
        aluctrl_s   = ALU_ADD;
        branch_s    = 1'b0;
        jump_s      = 1'b0;
        case (opcode_s)
            OP_R: begin
                regwrite_s = 1'b1;
                case (funct3_s)
                    3'b000:  aluctrl_s = funct7_s[5] ? ALU_SUB : ALU_ADD;
                    3'b001:  aluctrl_s = ALU_SLL;
                    3'b010:  aluctrl_s = ALU_SLT;
                    3'b011:  aluctrl_s = ALU_SLTU;
                    3'b100:  aluctrl_s = ALU_XOR;
                    3'b101:  aluctrl_s = funct7_s[5] ? ALU_SRA : ALU_SRL;
                    3'b110:  aluctrl_s = ALU_OR;
                    3'b111:  aluctrl_s = ALU_AND;
                    default: aluctrl_s = ALU_ADD;
                endcase
                // Only ADD/SUB and SRL/SRA have an alternate funct7
                if (funct7_s == 7'b0000000) begin
                    legal_s = 1'b1;
                end else if ((funct7_s == 7'b0100000) &&
                             ((funct3_s == 3'b000) || (funct3_s == 3'b101))) begin
                    legal_s = 1'b1;
                end else begin
                    legal_s = 1'b0;
                end
            end
            OP_IMM: begin
                regwrite_s = 1'b1;
                alusrcb_s  = 1'b1;
                imm_s      = {{20{instrD[31]}}, instrD[31:20]};
                case (funct3_s)
                    3'b000:  aluctrl_s = ALU_ADD;
                    3'b001:  aluctrl_s = ALU_SLL;
                    3'b010:  aluctrl_s = ALU_SLT;
                    3'b011:  aluctrl_s = ALU_SLTU;
                    3'b100:  aluctrl_s = ALU_XOR;
                    3'b101:  aluctrl_s = funct7_s[5] ? ALU_SRA : ALU_SRL;
                    3'b110:  aluctrl_s = ALU_OR;
                    3'b111:  aluctrl_s = ALU_AND;
                    default: aluctrl_s = ALU_ADD;
                endcase
                // Upper immediate bits are a funct7 only for the shifts
                if (funct3_s == 3'b001) begin
                    legal_s = (funct7_s == 7'b0000000);
                end else if (funct3_s == 3'b101) begin
                    legal_s = (funct7_s == 7'b0000000) || (funct7_s == 7'b0100000);
                end else begin
                    legal_s = 1'b1;
                end
            end
            OP_LOAD: begin
                regwrite_s  = 1'b1;
                resultsrc_s = 2'd1;
                alusrcb_s   = 1'b1;
                imm_s       = {{20{instrD[31]}}, instrD[31:20]};
                legal_s     = (funct3_s != 3'b011) && (funct3_s != 3'b110) &&
                              (funct3_s != 3'b111);
            end
            OP_STORE: begin
                memwrite_s = 1'b1;
                alusrcb_s  = 1'b1;
                imm_s      = {{20{instrD[31]}}, instrD[31:25], instrD[11:7]};
                legal_s    = (funct3_s == 3'b000) || (funct3_s == 3'b001) ||
                             (funct3_s == 3'b010);
            end
            OP_BRANCH: begin
                branch_s  = 1'b1;
                alusrca_s = 1'b1;
                alusrcb_s = 1'b1;
                imm_s     = {{19{instrD[31]}}, instrD[31], instrD[7],
                             instrD[30:25], instrD[11:8], 1'b0};
                legal_s   = (funct3_s != 3'b010) && (funct3_s != 3'b011);
            end
            OP_JAL: begin
                jump_s      = 1'b1;
                regwrite_s  = 1'b1;
                resultsrc_s = 2'd2;
                alusrca_s   = 1'b1;
                alusrcb_s   = 1'b1;
                imm_s       = {{11{instrD[31]}}, instrD[31], instrD[19:12],
                               instrD[20], instrD[30:21], 1'b0};
            end
            OP_JALR: begin
                jump_s      = 1'b1;
                regwrite_s  = 1'b1;
                resultsrc_s = 2'd2;
                alusrcb_s   = 1'b1;
                imm_s       = {{20{instrD[31]}}, instrD[31:20]};
                legal_s     = (funct3_s == 3'b000);
            end
            OP_LUI: begin
                regwrite_s = 1'b1;
                alusrcb_s  = 1'b1;
                aluctrl_s  = ALU_PASSB;
                imm_s      = {instrD[31:12], 12'h000};
            end
            OP_AUIPC: begin
                regwrite_s = 1'b1;
                alusrca_s  = 1'b1;
                alusrcb_s  = 1'b1;
                imm_s      = {instrD[31:12], 12'h000};
            end
            default: begin
                legal_s = 1'b0;
            end
        endcase
    end

    // ID/EX pipeline register: flush loads a bubble, illegal encodings lose their controls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd1E       <= {XLEN{1'b0}};
            rd2E       <= {XLEN{1'b0}};
            immE       <= {XLEN{1'b0}};
            pcE        <= {XLEN{1'b0}};
            pc4E       <= {XLEN{1'b0}};
            rs1E       <= 5'd0;
            rs2E       <= 5'd0;
            rdE        <= 5'd0;
            regwriteE  <= 1'b0;
            memwriteE  <= 1'b0;
            resultsrcE <= 2'd0;
            alusrcaE   <= 1'b0;
            alusrcbE   <= 1'b0;
            aluctrlE   <= 4'd0;
            branchE    <= 1'b0;
            jumpE      <= 1'b0;
            funct3E    <= 3'd0;
`ifdef DECODE_ILLEGAL_EN
            illegalE   <= 1'b0;
`endif
        end else if (flushE) begin
            rd1E       <= {XLEN{1'b0}};
            rd2E       <= {XLEN{1'b0}};
            immE       <= {XLEN{1'b0}};
            pcE        <= {XLEN{1'b0}};
            pc4E       <= {XLEN{1'b0}};
            rs1E       <= 5'd0;
            rs2E       <= 5'd0;
            rdE        <= 5'd0;
            regwriteE  <= 1'b0;
            memwriteE  <= 1'b0;
            resultsrcE <= 2'd0;
            alusrcaE   <= 1'b0;
            alusrcbE   <= 1'b0;
            aluctrlE   <= 4'd0;
            branchE    <= 1'b0;
            jumpE      <= 1'b0;
            funct3E    <= 3'd0;
`ifdef DECODE_ILLEGAL_EN
            illegalE   <= 1'b0;
`endif
        end else begin
            rd1E       <= rd1_s;
            rd2E       <= rd2_s;
            immE       <= imm_s;
            pcE        <= pcD;
            pc4E       <= pc4D;
            rs1E       <= rs1D;
            rs2E       <= rs2D;
            rdE        <= rdIdx_s;
            funct3E    <= funct3_s;
            regwriteE  <= regwrite_s & legal_s;
            memwriteE  <= memwrite_s & legal_s;
            resultsrcE <= legal_s ? resultsrc_s : 2'd0;
            alusrcaE   <= alusrca_s & legal_s;
            alusrcbE   <= alusrcb_s & legal_s;
            aluctrlE   <= legal_s ? aluctrl_s : 4'd0;
            branchE    <= branch_s & legal_s;
            jumpE      <= jump_s & legal_s;
`ifdef DECODE_ILLEGAL_EN
            illegalE   <= ~legal_s & (instrD != 32'h0000_0000);
`endif
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// Directed testbench for decode_stage: hand-encoded RV32I instructions with
// hand-computed ID/EX values checked one cycle after they are presented.
module tb_decode_stage;

    logic        clk;
    logic        rst_n;
    logic [31:0] instrD;
    logic [31:0] pcD;
    logic [31:0] pc4D;
    logic        flushE;
    logic        regwriteW;
    logic [4:0]  rdW;
    logic [31:0] resultW;
    logic [4:0]  rs1D;
    logic [4:0]  rs2D;
    logic [31:0] rd1E;
    logic [31:0] rd2E;
    logic [31:0] immE;
    logic [31:0] pcE;
    logic [31:0] pc4E;
    logic [4:0]  rs1E;
    logic [4:0]  rs2E;
    logic [4:0]  rdE;
    logic        regwriteE;
    logic        memwriteE;
    logic [1:0]  resultsrcE;
    logic        alusrcaE;
    logic        alusrcbE;
    logic [3:0]  aluctrlE;
    logic        branchE;
    logic        jumpE;
    logic [2:0]  funct3E;
`ifdef DECODE_ILLEGAL_EN
    logic        illegalE;
`endif

    int assertCount = 0;
    int failCount   = 0;

    decode_stage dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .instrD     (instrD),
        .pcD        (pcD),
        .pc4D       (pc4D),
        .flushE     (flushE),
        .regwriteW  (regwriteW),
        .rdW        (rdW),
        .resultW    (resultW),
        .rs1D       (rs1D),
        .rs2D       (rs2D),
        .rd1E       (rd1E),
        .rd2E       (rd2E),
        .immE       (immE),
        .pcE        (pcE),
        .pc4E       (pc4E),
        .rs1E       (rs1E),
        .rs2E       (rs2E),
        .rdE        (rdE),
        .regwriteE  (regwriteE),
        .memwriteE  (memwriteE),
        .resultsrcE (resultsrcE),
        .alusrcaE   (alusrcaE),
        .alusrcbE   (alusrcbE),
        .aluctrlE   (aluctrlE),
        .branchE    (branchE),
        .jumpE      (jumpE),
        .funct3E    (funct3E)
`ifdef DECODE_ILLEGAL_EN
        ,
        .illegalE   (illegalE)
`endif
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assertCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // One rising edge, then settle before sampling
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // All control outputs packed: regwrite,memwrite,resultsrc,srca,srcb,aluctrl,branch,jump
    function automatic logic [31:0] ctrlWord();
        return {19'd0, regwriteE, memwriteE, resultsrcE, alusrcaE, alusrcbE,
                aluctrlE, branchE, jumpE, 1'b0};
    endfunction

    function automatic logic [31:0] mkCtrl(input logic rw, input logic mw, input logic [1:0] rs,
                                           input logic sa, input logic sb, input logic [3:0] alu,
                                           input logic br, input logic jp);
        return {19'd0, rw, mw, rs, sa, sb, alu, br, jp, 1'b0};
    endfunction

    task automatic checkAllZero(input string tag);
        check({tag, "_ctrl"}, ctrlWord(), 32'd0);
        check({tag, "_rd1"},  rd1E, 32'd0);
        check({tag, "_rd2"},  rd2E, 32'd0);
        check({tag, "_imm"},  immE, 32'd0);
        check({tag, "_pc"},   pcE, 32'd0);
        check({tag, "_pc4"},  pc4E, 32'd0);
        check({tag, "_idx"},  {17'd0, rs1E, rs2E, rdE}, 32'd0);
        check({tag, "_f3"},   {29'd0, funct3E}, 32'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        instrD    = 32'h0050_0093;
        pcD       = 32'h0000_0010;
        pc4D      = 32'h0000_0014;
        flushE    = 1'b0;
        regwriteW = 1'b0;
        rdW       = 5'd0;
        resultW   = 32'd0;

        // Reset holds all E outputs at zero even with clocks and a valid instruction
        repeat (2) @(posedge clk);
        #1;
        checkAllZero("reset");
        check("rs1D_comb", {27'd0, rs1D}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // addi x1,x0,5
        cycle();
        check("addi_ctrl", ctrlWord(), mkCtrl(1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0));
        check("addi_imm", immE, 32'd5);
        check("addi_rd", {27'd0, rdE}, 32'd1);
        check("addi_pc", pcE, 32'h0000_0010);
        check("addi_pc4", pc4E, 32'h0000_0014);

        // add x2,x1,x1 while writeback writes x1=0x1234: bypass
        instrD = 32'h0010_8133; regwriteW = 1'b1; rdW = 5'd1; resultW = 32'h0000_1234;
        #1;
        check("add_rs1D", {27'd0, rs1D}, 32'd1);
        check("add_rs2D", {27'd0, rs2D}, 32'd1);
        cycle();
        check("byp_rd1", rd1E, 32'h0000_1234);
        check("byp_rd2", rd2E, 32'h0000_1234);
        check("add_ctrl", ctrlWord(), mkCtrl(1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0));
        check("add_rd", {27'd0, rdE}, 32'd2);
        check("add_imm", immE, 32'd0);

        // Same read from storage, and write x0=0xFFFF in the same cycle
        regwriteW = 1'b1; rdW = 5'd0; resultW = 32'h0000_FFFF;
        cycle();
        check("stored_rd1", rd1E, 32'h0000_1234);
        // add x2,x0,x0 after the x0 write attempt and during another one
        instrD = 32'h0000_0133;
        cycle();
        check("x0_rd1", rd1E, 32'd0);
        check("x0_rd2", rd2E, 32'd0);
        regwriteW = 1'b0; rdW = 5'd0; resultW = 32'd0;

        // beq x0,x0,-4 at pc 0x40
        instrD = 32'hFE00_0EE3; pcD = 32'h0000_0040; pc4D = 32'h0000_0044;
        cycle();
        check("beq_ctrl", ctrlWord(), mkCtrl(1'b0, 1'b0, 2'd0, 1'b1, 1'b1, 4'd0, 1'b1, 1'b0));
        check("beq_imm", immE, 32'hFFFF_FFFC);
        check("beq_f3", {29'd0, funct3E}, 32'd0);
        check("beq_pc", pcE, 32'h0000_0040);

        // jal x1,8
        instrD = 32'h0080_00EF;
        cycle();
        check("jal_ctrl", ctrlWord(), mkCtrl(1'b1, 1'b0, 2'd2, 1'b1, 1'b1, 4'd0, 1'b0, 1'b1));
        check("jal_imm", immE, 32'd8);

        // lui x1,0x12345
        instrD = 32'h1234_50B7;
        cycle();
        check("lui_ctrl", ctrlWord(), mkCtrl(1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 4'd10, 1'b0, 1'b0));
        check("lui_imm", immE, 32'h1234_5000);

        // sw x1,8(x0)
        instrD = 32'h0010_2423;
        cycle();
        check("sw_ctrl", ctrlWord(), mkCtrl(1'b0, 1'b1, 2'd0, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0));
        check("sw_imm", immE, 32'd8);
        check("sw_f3", {29'd0, funct3E}, 32'd2);
        check("sw_rd2", rd2E, 32'h0000_1234);

        // lw x4,4(x1)
        instrD = 32'h0040_A203;
        cycle();
        check("lw_ctrl", ctrlWord(), mkCtrl(1'b1, 1'b0, 2'd1, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0));
        check("lw_imm", immE, 32'd4);

        // srai x5,x1,3 honours funct7[5]
        instrD = 32'h4030_D293;
        cycle();
        check("srai_alu", {28'd0, aluctrlE}, 32'd7);
        check("srai_imm", immE, 32'h0000_0403);

        // addi x1,x1,-1 has instr[30]=1 but stays ADD
        instrD = 32'hFFF0_8093;
        cycle();
        check("addineg_alu", {28'd0, aluctrlE}, 32'd0);
        check("addineg_imm", immE, 32'hFFFF_FFFF);

        // sub x3,x1,x2 with flush: bubble wins
        instrD = 32'h4020_81B3; flushE = 1'b1;
        cycle();
        checkAllZero("flush");
        flushE = 1'b0;
        cycle();
        check("sub_ctrl", ctrlWord(), mkCtrl(1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 4'd1, 1'b0, 1'b0));
        check("sub_idx", {17'd0, rs1E, rs2E, rdE}, {17'd0, 5'd1, 5'd2, 5'd3});
        check("sub_rd1", rd1E, 32'h0000_1234);

        // All-zero instruction is a bubble for the controls
        instrD = 32'h0000_0000;
        cycle();
        check("bubble_ctrl", ctrlWord(), 32'd0);
        check("bubble_rd", {27'd0, rdE}, 32'd0);

        // Unsupported opcode 0x7F decodes with controls cleared
        instrD = 32'h0000_007F;
        cycle();
        check("illop_ctrl", ctrlWord(), 32'd0);
`ifdef DECODE_ILLEGAL_EN
        check("illop_flag", {31'd0, illegalE}, 32'd1);
        flushE = 1'b1;
        cycle();
        check("illflush_flag", {31'd0, illegalE}, 32'd0);
        flushE = 1'b0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
